// File: rtl/programmable_minterm_unit.sv
// Run-time programmable N_IN-input boolean function with a loadable truth table,
// a 1-deep valid/ready evaluation stage and a popcount sweep engine.
// Optional table readback port is compiled in when PMU_READBACK_EN is defined.
module programmable_minterm_unit #(
  parameter int N_IN   = 5,
  parameter int LOAD_W = 8,
  localparam int TBL    = 1 << N_IN,
  localparam int NWORDS = TBL / LOAD_W,
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tbl_clr,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [LOAD_W-1:0] i_ld_data,
  output logic              o_table_valid,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [N_IN-1:0]   i_in_vec,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_bit,
  input  logic              i_sweep_start,
  output logic              o_sweep_busy,
  output logic              o_sweep_done,
  output logic [N_IN:0]     o_minterm_count
`ifdef PMU_READBACK_EN
  ,
  input  logic [IDX_W-1:0]  i_rb_idx,
  output logic [LOAD_W-1:0] o_rb_data
`endif
);

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_ACTIVE = 2'd1, S_SWEEP = 2'd2} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TBL-1:0]    r_table;
  logic [IDX_W-1:0]  r_idx;
  logic              r_table_valid;
  logic              r_out_valid;
  logic              r_out_bit;
  logic [N_IN-1:0]   r_sidx;
  logic [N_IN:0]     r_cnt;
  logic              r_sweep_done;
  logic [N_IN:0]     r_minterm_count;
  logic              w_ld_acc;
  logic              w_in_acc;
  logic              w_last_word;
  logic              w_sweep_go;
  logic [N_IN:0]     w_cnt_nxt;

  assign w_last_word = (r_idx == IDX_W'(NWORDS - 1));
  assign w_cnt_nxt   = r_cnt + (N_IN+1)'(r_table[r_sidx]);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_LOAD;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_ld_ready   = 1'b0;
    o_in_ready   = 1'b0;
    o_sweep_busy = 1'b0;
    w_ld_acc     = 1'b0;
    w_in_acc     = 1'b0;
    w_sweep_go   = 1'b0;
    case (r_state)
      S_LOAD: begin
        o_ld_ready = 1'b1;
        w_ld_acc   = i_ld_valid;
        if (w_ld_acc && w_last_word) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        o_in_ready = !r_out_valid || i_out_ready;
        w_in_acc   = i_in_valid && o_in_ready;
        // a pending result blocks the sweep so the output stage is idle on entry
        w_sweep_go = i_sweep_start && !r_out_valid;
        if (w_sweep_go) w_state_nxt = S_SWEEP;
      end
      S_SWEEP: begin
        o_sweep_busy = 1'b1;
        if (&r_sidx) w_state_nxt = S_ACTIVE;
      end
      default: w_state_nxt = S_LOAD;
    endcase
    if (i_tbl_clr) w_state_nxt = S_LOAD;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_table         <= '0;
      r_idx           <= '0;
      r_table_valid   <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_bit       <= 1'b0;
      r_sidx          <= '0;
      r_cnt           <= '0;
      r_sweep_done    <= 1'b0;
      r_minterm_count <= '0;
    end else if (i_tbl_clr) begin
      r_table       <= '0;
      r_idx         <= '0;
      r_table_valid <= 1'b0;
      r_out_valid   <= 1'b0;
      r_sweep_done  <= 1'b0;
    end else begin
      r_sweep_done <= 1'b0;
      if (w_ld_acc) begin
        r_table[int'(r_idx)*LOAD_W +: LOAD_W] <= i_ld_data;
        r_idx <= w_last_word ? '0 : r_idx + 1'b1;
        if (w_last_word) r_table_valid <= 1'b1;
      end
      if (w_in_acc) begin
        r_out_bit   <= r_table[i_in_vec];
        r_out_valid <= 1'b1;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_sweep_go) begin
        r_cnt  <= '0;
        r_sidx <= '0;
      end
      if (r_state == S_SWEEP) begin
        r_cnt  <= w_cnt_nxt;
        r_sidx <= r_sidx + 1'b1;
        if (&r_sidx) begin
          r_minterm_count <= w_cnt_nxt;
          r_sweep_done    <= 1'b1;
        end
      end
    end
  end

`ifdef PMU_READBACK_EN
  logic [LOAD_W-1:0] r_rb_data;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_rb_data <= '0;
    else         r_rb_data <= r_table[int'(i_rb_idx)*LOAD_W +: LOAD_W];
  end
  assign o_rb_data = r_rb_data;
`endif

  assign o_table_valid   = r_table_valid;
  assign o_out_valid     = r_out_valid;
  assign o_out_bit       = r_out_bit;
  assign o_sweep_done    = r_sweep_done;
  assign o_minterm_count = r_minterm_count;

endmodule

// File: tb/tb_programmable_minterm_unit.sv
// Scoreboard bench for programmable_minterm_unit (N_IN=5, LOAD_W=8).
module tb_programmable_minterm_unit;
  localparam int N_IN = 5;
  localparam int LOAD_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tbl_clr = 1'b0, ld_valid = 1'b0, ld_ready;
  logic [LOAD_W-1:0] ld_data = '0;
  logic table_valid;
  logic in_valid = 1'b0, in_ready;
  logic [N_IN-1:0] in_vec = '0;
  logic out_valid, out_ready = 1'b1, out_bit;
  logic sweep_start = 1'b0, sweep_busy, sweep_done;
  logic [N_IN:0] minterm_count;
`ifdef PMU_READBACK_EN
  logic [1:0] rb_idx = '0;
  logic [LOAD_W-1:0] rb_data;
`endif

  programmable_minterm_unit #(.N_IN(N_IN), .LOAD_W(LOAD_W)) dut (
    .i_clk(clk), .i_reset(rst), .i_tbl_clr(tbl_clr),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_data(ld_data),
    .o_table_valid(table_valid),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_vec(in_vec),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_bit(out_bit),
    .i_sweep_start(sweep_start), .o_sweep_busy(sweep_busy), .o_sweep_done(sweep_done),
    .o_minterm_count(minterm_count)
`ifdef PMU_READBACK_EN
    , .i_rb_idx(rb_idx), .o_rb_data(rb_data)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_tbl = '0;
  logic [N_IN:0] m_count = '0;
  bit sb_q[$];

  // Drives the four load words; reports table_valid seen during the final handshake cycle.
  task automatic load_table(input logic [31:0] t, output logic tv_before, output bit timeout);
    bit hs;
    int n;
    timeout = 0;
    tv_before = 1'bx;
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1;
      ld_data = t[k*8 +: 8];
      n = 0;
      hs = 0;
      while (!hs && n < 10) begin
        @(negedge clk);
        hs = ld_ready;
        if (k == 3) tv_before = table_valid;
        @(posedge clk); #1;
        n++;
      end
      if (!hs) timeout = 1;
    end
    ld_valid = 1'b0;
  endtask

  task automatic run_sweep(input int abort_at, output int busy_cyc, output int done_at,
                           output int done_pulses, output logic [N_IN:0] cnt_at_done);
    busy_cyc = 0; done_at = 0; done_pulses = 0; cnt_at_done = '0;
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == abort_at) tbl_clr = 1'b1;
      @(negedge clk);
      if (sweep_busy) busy_cyc++;
      if (sweep_done) begin
        done_pulses++;
        if (done_at == 0) begin done_at = c; cnt_at_done = minterm_count; end
      end
      @(posedge clk); #1;
      tbl_clr = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ld_ready: got %b expected 1", ld_ready); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (table_valid !== 1'b0) begin n_fail++; $display("FAIL rst_table_valid: got %b expected 0", table_valid); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_bit !== 1'b0) begin n_fail++; $display("FAIL rst_out_bit: got %b expected 0", out_bit); end
    n_tests++; if (sweep_busy !== 1'b0 || sweep_done !== 1'b0) begin n_fail++; $display("FAIL rst_sweep: got busy=%b done=%b expected 0/0", sweep_busy, sweep_done); end
    n_tests++; if (minterm_count !== '0) begin n_fail++; $display("FAIL rst_minterm_count: got %0d expected 0", minterm_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hAA;
    @(posedge clk); #1;
    ld_data = 8'h55;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++; if (ld_ready !== 1'b1 || table_valid !== 1'b0) begin n_fail++; $display("FAIL midload_reset: got ld_ready=%b table_valid=%b expected 1/0", ld_ready, table_valid); end
    n_tests++; if (out_valid !== 1'b0 || minterm_count !== '0) begin n_fail++; $display("FAIL midload_reset_out: got out_valid=%b count=%0d expected 0/0", out_valid, minterm_count); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_load_eval;
    logic tvb;
    bit to;
    logic [N_IN-1:0] vecs [4];
    int idx, cyc, got;
    bit e;
    vecs[0] = 5'd0; vecs[1] = 5'd3; vecs[2] = 5'd4; vecs[3] = 5'd31;
    m_tbl = 32'h8000_0017;
    load_table(m_tbl, tvb, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL load_handshake: got timeout expected ld_ready"); end
    n_tests++; if (tvb !== 1'b0) begin n_fail++; $display("FAIL tv_early: got %b expected 0", tvb); end
    n_tests++; if (table_valid !== 1'b1) begin n_fail++; $display("FAIL tv_after_load: got %b expected 1", table_valid); end
    n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL ld_ready_full: got %b expected 0", ld_ready); end
    idx = 0; cyc = 0; got = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_vec = vecs[0];
    while ((idx < 4 || sb_q.size() > 0) && cyc < 20) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL eval_spurious: got out_valid=1 expected no result"); end
        else begin
          e = sb_q.pop_front();
          got++;
          if (out_bit !== e) begin n_fail++; $display("FAIL eval_bit%0d: got %b expected %b", got, out_bit, e); end
        end
      end
      if (in_valid && in_ready) begin sb_q.push_back(m_tbl[in_vec]); idx++; end
      @(posedge clk); #1;
      if (idx < 4) in_vec = vecs[idx]; else in_valid = 1'b0;
      cyc++;
    end
    n_tests++; if (got != 4 || cyc != 5) begin n_fail++; $display("FAIL eval_throughput: got %0d results in %0d cycles expected 4 in 5", got, cyc); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL eval_drain: got out_valid=%b expected 0", out_valid); end
    @(posedge clk); #1;
  endtask

`ifdef PMU_READBACK_EN
  task automatic test_readback;
    rb_idx = 2'd3;
    @(posedge clk); #1;
    n_tests++; if (rb_data !== m_tbl[31:24]) begin n_fail++; $display("FAIL rb_word3: got %h expected %h", rb_data, m_tbl[31:24]); end
    rb_idx = 2'd0;
    @(posedge clk); #1;
    n_tests++; if (rb_data !== m_tbl[7:0]) begin n_fail++; $display("FAIL rb_word0: got %h expected %h", rb_data, m_tbl[7:0]); end
  endtask
`endif

  task automatic test_backpressure;
    bit e;
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 5'd4;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 1", in_ready); end
    if (in_valid && in_ready) sb_q.push_back(m_tbl[in_vec]);
    @(posedge clk); #1;
    in_vec = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d: got out_valid=%b in_ready=%b expected 1/0", i, out_valid, in_ready); end
      n_tests++; if (sb_q.size() == 0 || out_bit !== sb_q[0]) begin n_fail++; $display("FAIL bp_hold%0d: got %b expected %b", i, out_bit, m_tbl[4]); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    n_tests++;
    if (!out_valid || sb_q.size() == 0) begin n_fail++; $display("FAIL bp_release_out: got out_valid=%b expected 1", out_valid); end
    else begin
      e = sb_q.pop_front();
      if (out_bit !== e) begin n_fail++; $display("FAIL bp_release_bit: got %b expected %b", out_bit, e); end
    end
    if (in_valid && in_ready) sb_q.push_back(m_tbl[in_vec]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (!out_valid || sb_q.size() == 0) begin n_fail++; $display("FAIL bp_second_out: got out_valid=%b queued=%0d expected 1/1", out_valid, sb_q.size()); end
    else begin
      e = sb_q.pop_front();
      if (out_bit !== e) begin n_fail++; $display("FAIL bp_second_bit: got %b expected %b", out_bit, e); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got out_valid=%b expected 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep;
    int busy, done_at, pulses;
    logic [N_IN:0] cnt;
    logic tvb;
    bit to;
    m_count = (N_IN+1)'($countones(m_tbl));
    run_sweep(0, busy, done_at, pulses, cnt);
    n_tests++; if (busy != 32) begin n_fail++; $display("FAIL sweep_busy_len: got %0d expected 32", busy); end
    n_tests++; if (done_at != 33 || pulses != 1) begin n_fail++; $display("FAIL sweep_done_time: got cycle %0d pulses %0d expected 33/1", done_at, pulses); end
    n_tests++; if (cnt !== m_count) begin n_fail++; $display("FAIL sweep_count: got %0d expected %0d", cnt, m_count); end
    tbl_clr = 1'b1;
    @(posedge clk); #1;
    tbl_clr = 1'b0;
    n_tests++; if (minterm_count !== m_count) begin n_fail++; $display("FAIL clr_keeps_count: got %0d expected %0d", minterm_count, m_count); end
    m_tbl = 32'hFFFF_FFFF;
    load_table(m_tbl, tvb, to);
    m_count = (N_IN+1)'($countones(m_tbl));
    run_sweep(0, busy, done_at, pulses, cnt);
    n_tests++; if (cnt !== m_count || done_at != 33) begin n_fail++; $display("FAIL sweep_all_ones: got %0d at %0d expected %0d at 33", cnt, done_at, m_count); end
  endtask

  task automatic test_clr_during_sweep;
    int busy, done_at, pulses;
    logic [N_IN:0] cnt;
    run_sweep(10, busy, done_at, pulses, cnt);
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", pulses); end
    n_tests++; if (busy != 10) begin n_fail++; $display("FAIL abort_busy: got %0d cycles expected 10", busy); end
    @(negedge clk);
    n_tests++; if (ld_ready !== 1'b1 || in_ready !== 1'b0 || table_valid !== 1'b0) begin n_fail++; $display("FAIL abort_state: got ld_ready=%b in_ready=%b tv=%b expected 1/0/0", ld_ready, in_ready, table_valid); end
    n_tests++; if (minterm_count !== m_count) begin n_fail++; $display("FAIL abort_count: got %0d expected %0d", minterm_count, m_count); end
    @(posedge clk); #1;
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    @(negedge clk);
    n_tests++; if (sweep_busy !== 1'b0) begin n_fail++; $display("FAIL sweep_in_load: got busy=%b expected 0", sweep_busy); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_load_eval();
`ifdef PMU_READBACK_EN
    test_readback();
`endif
    test_backpressure();
    test_sweep();
    test_clr_during_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
